adc_fifo_reader: RTL and testbench
==================================

Name: adc_fifo_reader

Overview:
- Read side of the ADC capture FIFO. The capture block writes 72-bit words into that FIFO, each holding four 16-bit samples.
- This block drains the FIFO in bursts of programmable length and restores the 64-bit sample ordering.
- It presents the words on a valid/ready stream to the DMA/host path and raises user_int when each burst completes.
- All logic is in the FIFO read clock domain.

Parameters:
- FIFO_W, 72, FIFO word width; bits [71:64] are a tag that must be zero.
- DATA_W, 64, output word width (four 16-bit samples).
- CNT_W, 32, width of the burst-length register and the word counters.
- BURST_DEFAULT, 1024, burst length in words after reset.

Ports:
- clk  in  1  FIFO read clock; the only clock in the block.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  level; starts bursts and keeps them repeating.
- burst_len  in  CNT_W  new burst length in words, from a host register.
- burst_len_tv  in  1  one-cycle load strobe for burst_len.
- irq_ack  in  1  host acknowledge for user_int.
- fifo_dout  in  FIFO_W  FIFO read data.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read enable.
- m_data  out  DATA_W  output word.
- m_valid  out  1  output word is valid.
- m_ready  in  1  downstream accepts the word.
- m_last  out  1  marks the last word of a burst.
- user_int  out  1  burst-complete interrupt, held as a level.
- words_done  out  CNT_W  count of words accepted downstream in the current burst.
- tag_err  out  1  sticky flag: a word arrived with a nonzero tag.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; burst length register = BURST_DEFAULT; internal buffer empty; issued counter 0.
- FIFO read timing: the FIFO is standard, not first-word-fall-through. Data appears on fifo_dout in the cycle after fifo_rd_en, and the block captures it in that cycle.
- Word remap of each captured word w:
  - m_data[63:32] = w[31:0]
  - m_data[31:0] = w[63:32]
  - After the remap, sample 0 sits at m_data[15:0] and sample 3 at m_data[63:48].
  - If w[71:64] != 0, tag_err is set. The word is still delivered.
- Burst-length loading:
  - burst_len is loaded only when burst_len_tv=1 and state=IDLE.
  - A strobe in any other state is ignored.
  - A value of 0 is ignored; the previous value is kept.
- Buffering: a 2-entry skid buffer sits between the FIFO and the output. Occupancy plus in-flight reads never exceeds 2.
- fifo_rd_en is asserted when all of these hold:
  - state=RUN
  - enable=1
  - fifo_empty=0
  - (occupancy + in-flight) < 2
  - issued < burst length
- Output handshake:
  - m_valid=1 when the buffer is non-empty; m_data shows the head entry.
  - A transfer happens when m_valid & m_ready; words_done then increments.
  - m_data and m_valid hold stable while m_valid=1 and m_ready=0.
  - m_last=1 together with m_valid on the word where words_done = burst length − 1.
- Throughput: one word per clock sustained when m_ready is held at 1 and the FIFO is non-empty.
- Latency: the first m_valid appears 2 cycles after the first fifo_rd_en.
- State machine:
  - IDLE → RUN when enable=1. On this transition words_done, issued and tag_err are cleared.
  - RUN → DONE on the transfer that carries m_last.
  - RUN → IDLE when enable falls:
    - No new reads are issued.
    - In-flight reads and buffered words are still delivered; m_last is not asserted on them.
    - The block goes to IDLE once the buffer is empty and no reads are in flight.
    - No interrupt is raised; words_done holds its value.
  - DONE: user_int=1 and no reads are issued. irq_ack → IDLE with user_int=0 in the following cycle. If enable is still 1, the next burst starts one cycle later through IDLE.
  - irq_ack is sampled only in DONE. An ack asserted in the same cycle as the transition into DONE is ignored.
- Counters: issued and words_done are bounded by the burst length and never wrap.
- fifo_empty during RUN stalls the reader only; the state is unchanged.
- Reset mid-burst: reset applies immediately. Buffered words and any in-flight FIFO read are discarded; that word is lost.

Test Plan:
- Basic burst: burst_len=4 with strobe in IDLE; FIFO holds 4 words with w[63:32]=0x33334444_x, w[31:0]=0x11112222_x; enable=1, m_ready=1.
  - Expect 4 transfers on consecutive cycles, m_data=0x11112222_33334444-pattern, m_last on word 4.
  - Expect user_int=1 until irq_ack, then user_int=0 and words_done=4.
- Backpressure: burst_len=8; m_ready toggles 1,0,0,1…
  - Expect no FIFO reads beyond occupancy 2, m_data stable while stalled, exactly 8 words in order, no duplicates.
- FIFO underrun: FIFO empty for 10 cycles mid-burst.
  - Expect fifo_rd_en=0 and m_valid=0 after drain, resume on refill, m_last still on word burst_len.
- Tag and config guard: one word carries w[71:64]=0x5A.
  - Expect tag_err=1, held until the next IDLE→RUN.
  - A burst_len_tv pulse during RUN, and one with value 0, leave the burst length unchanged.
- Enable drop and ack timing: enable falls after 3 of 16 words.
  - Expect delivery to stop at ≤5 words, IDLE, user_int=0.
  - Separately, irq_ack in the same cycle DONE is entered is ignored; user_int stays 1.
- Reset mid-burst: reset for 1 cycle after word 2 of 8.
  - Expect next cycle: all outputs 0, busy=0, burst length=1024, buffer empty.

Source files
------------

// File: rtl/adc_fifo_reader_if.sv
// ---------------------------------------------------------------------------
// adc_fifo_reader_if
//   Groups the two data paths of the ADC FIFO reader into one bundle: the
//   FIFO read port (standard FIFO, not first-word-fall-through) and the
//   valid/ready output stream towards the DMA/host path.
//
//   master : the reader. It drives fifo_rd_en and the m_* stream.
//   slave  : the environment. It drives FIFO data/flags and m_ready.
//
//   fifo_dout  [FIFO_W] FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty          FIFO empty flag
//   fifo_rd_en          FIFO read enable
//   m_data     [DATA_W] output word
//   m_valid             output word is valid
//   m_ready             downstream accepts the word
//   m_last              last word of a burst
// ---------------------------------------------------------------------------
interface adc_fifo_reader_if #(
  parameter int FIFO_W = 72,
  parameter int DATA_W = 64
);
  logic [FIFO_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (
    input  fifo_dout, fifo_empty, m_ready,
    output fifo_rd_en, m_data, m_valid, m_last
  );

  modport slave (
    output fifo_dout, fifo_empty, m_ready,
    input  fifo_rd_en, m_data, m_valid, m_last
  );
endinterface

// File: rtl/adc_fifo_reader.sv
// ---------------------------------------------------------------------------
// adc_fifo_reader
//   Read side of the ADC capture FIFO. Drains the FIFO in bursts of a
//   programmable number of words, swaps the two 32-bit halves of each word to
//   restore sample order (sample 0 ends up in m_data[15:0]), and presents the
//   words on a valid/ready stream. A level interrupt is raised when a burst
//   completes and is cleared by irq_ack.
//
// Ports
//   clk, reset     FIFO read clock; synchronous active-high reset
//   enable         level; starts bursts and keeps them repeating
//   burst_len/_tv  burst length and its one-cycle load strobe (IDLE only)
//   irq_ack        host acknowledge for user_int (sampled only in DONE)
//   bus            FIFO read port and output stream (master side)
//   user_int       burst-complete interrupt, level
//   words_done     words accepted downstream in the current burst
//   tag_err        sticky: a FIFO word carried a nonzero tag byte
//   busy           state is not IDLE
// ---------------------------------------------------------------------------
module adc_fifo_reader #(
  parameter int FIFO_W        = 72,
  parameter int DATA_W        = 64,
  parameter int CNT_W         = 32,
  parameter int BURST_DEFAULT = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [CNT_W-1:0]      burst_len,
  input  logic                  burst_len_tv,
  input  logic                  irq_ack,
  adc_fifo_reader_if.master     bus,
  output logic                  user_int,
  output logic [CNT_W-1:0]      words_done,
  output logic                  tag_err,
  output logic                  busy
);

  localparam int HALF = DATA_W / 2;

  // DRAIN is the tail of a burst cut short by enable falling: no new reads,
  // outstanding words are still delivered, then back to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  burst_len_q, burst_len_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  words_done_q, words_done_d;
  logic [DATA_W-1:0] buf0_q, buf0_d;   // head of the skid buffer
  logic [DATA_W-1:0] buf1_q, buf1_d;
  logic [1:0]        occ_q, occ_d;
  logic              pend_q, pend_d;   // FIFO read issued last cycle
  logic              tag_err_q, tag_err_d;
  logic              user_int_q, user_int_d;

  logic              push;
  logic              pop;
  logic              rd_en;
  logic              last_word;
  logic [2:0]        credit;
  logic [DATA_W-1:0] cap_data;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    // Half swap: low 32 bits of the FIFO word become the upper half.
    cap_data  = {bus.fifo_dout[HALF-1:0], bus.fifo_dout[DATA_W-1:HALF]};
    push      = pend_q;
    pop       = (occ_q != 2'd0) && bus.m_ready;
    last_word = (state_q == RUN) && (words_done_q == burst_len_q - CNT_W'(1));

    // Slots committed after this cycle: a word leaving this cycle frees its
    // slot in time for a new read, which keeps one word per clock sustained.
    credit = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop};
    rd_en  = (state_q == RUN) && enable && !bus.fifo_empty &&
             (credit < 3'd2) && (issued_q < burst_len_q);

    buf0_d = buf0_q;
    buf1_d = buf1_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = cap_data;
        else               buf1_d = cap_data;
      end
      2'b01: buf0_d = buf1_q;
      2'b11: begin
        if (occ_q == 2'd1) buf0_d = cap_data;
        else begin
          buf0_d = buf1_q;
          buf1_d = cap_data;
        end
      end
      default: ;
    endcase
    occ_d  = occ_q + {1'b0, push} - {1'b0, pop};
    pend_d = rd_en;

    issued_d     = issued_q + CNT_W'(rd_en);
    words_done_d = words_done_q + CNT_W'(pop);
    tag_err_d    = tag_err_q | (pend_q && (|bus.fifo_dout[FIFO_W-1:DATA_W]));

    // A zero length would never complete a burst, so it is refused.
    burst_len_d = burst_len_q;
    if ((state_q == IDLE) && burst_len_tv && (burst_len != '0))
      burst_len_d = burst_len;

    state_d    = state_q;
    user_int_d = user_int_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d      = RUN;
          issued_d     = '0;
          words_done_d = '0;
          tag_err_d    = 1'b0;
        end
      end
      RUN: begin
        // Completing the burst wins over a simultaneous enable drop.
        if (pop && last_word) begin
          state_d    = DONE;
          user_int_d = 1'b1;
        end else if (!enable) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // No reads are issued here, so an empty buffer means nothing is left.
        if (occ_d == 2'd0 && !pend_q) state_d = IDLE;
      end
      DONE: begin
        if (irq_ack) begin
          state_d    = IDLE;
          user_int_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      burst_len_q  <= CNT_W'(BURST_DEFAULT);
      issued_q     <= '0;
      words_done_q <= '0;
      // NOTE: the two buffer entries are reset as well because the head entry
      // drives m_data directly and must read zero out of reset.
      buf0_q       <= '0;
      buf1_q       <= '0;
      occ_q        <= '0;
      pend_q       <= 1'b0;
      tag_err_q    <= 1'b0;
      user_int_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_len_q  <= burst_len_d;
      issued_q     <= issued_d;
      words_done_q <= words_done_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      occ_q        <= occ_d;
      pend_q       <= pend_d;
      tag_err_q    <= tag_err_d;
      user_int_q   <= user_int_d;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_data     = buf0_q;
  assign bus.m_valid    = (occ_q != 2'd0);
  assign bus.m_last     = last_word && (occ_q != 2'd0);
  assign user_int       = user_int_q;
  assign words_done     = words_done_q;
  assign tag_err        = tag_err_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_adc_fifo_reader.sv
// ---------------------------------------------------------------------------
// tb_adc_fifo_reader
//   Directed burst scenarios with random sample data. A word-array FIFO model
//   feeds the reader; the expected output of a burst is the list of words
//   pushed into that FIFO with their 32-bit halves swapped. A negedge monitor
//   records every accepted word, stall stability and outstanding reads.
// ---------------------------------------------------------------------------
module tb_adc_fifo_reader;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [31:0] burst_len;
  logic        burst_len_tv;
  logic        irq_ack;
  logic        user_int;
  logic [31:0] words_done;
  logic        tag_err;
  logic        busy;

  adc_fifo_reader_if bus ();

  adc_fifo_reader dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .burst_len    (burst_len),
    .burst_len_tv (burst_len_tv),
    .irq_ack      (irq_ack),
    .bus          (bus),
    .user_int     (user_int),
    .words_done   (words_done),
    .tag_err      (tag_err),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- FIFO model (standard read timing) ----------------
  logic [71:0] fifo_mem [0:255];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        starve = 1'b0;
  logic        flush  = 1'b0;

  assign bus.fifo_empty = starve || (rd_ptr >= wr_ptr);

  always @(posedge clk) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (bus.fifo_rd_en) begin
      bus.fifo_dout <= fifo_mem[rd_ptr[7:0]];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  // ---------------- reference: expected words of current burst -------
  logic [63:0] exp_q [$];

  // ---------------- monitor ----------------
  logic [63:0] obs_data [$];
  logic        obs_last [$];
  int          obs_cyc  [$];
  int          cyc         = 0;
  int          reads       = 0;
  int          xfers       = 0;
  int          max_out     = 0;
  int          stable_viol = 0;
  int          first_rd    = -1;
  int          first_vld   = -1;
  logic        prev_stall  = 1'b0;
  logic [63:0] prev_data   = '0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      reads      = 0;
      xfers      = 0;
      prev_stall = 1'b0;
    end else begin
      if (bus.fifo_rd_en) begin
        reads++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (bus.m_valid && first_vld < 0) first_vld = cyc;
      if (prev_stall && !(bus.m_valid && bus.m_data == prev_data)) stable_viol++;
      if (bus.m_valid && bus.m_ready) begin
        xfers++;
        obs_data.push_back(bus.m_data);
        obs_last.push_back(bus.m_last);
        obs_cyc.push_back(cyc);
      end
      if (reads - xfers > max_out) max_out = reads - xfers;
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic new_burst();
    exp_q.delete();
    obs_data.delete();
    obs_last.delete();
    obs_cyc.delete();
  endtask

  task automatic push_word(input logic [71:0] w);
    fifo_mem[wr_ptr[7:0]] = w;
    wr_ptr++;
    exp_q.push_back({w[31:0], w[63:32]});
  endtask

  task automatic load_len(input logic [31:0] v);
    burst_len    = v;
    burst_len_tv = 1'b1;
    step();
    burst_len_tv = 1'b0;
  endtask

  task automatic wait_xfers(input int n, input int budget);
    int k = 0;
    while (obs_data.size() < n && k < budget) begin
      step();
      k++;
    end
  endtask

  task automatic wait_int(input string tag, input int budget);
    int k = 0;
    while (!user_int && k < budget) begin
      step();
      k++;
    end
    check(tag, user_int, 1'b1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      step();
      k++;
    end
    check(tag, busy, 1'b0);
  endtask

  // Compares the delivered words with the reference list; last_idx is the
  // only index allowed to carry m_last (-1: none).
  task automatic check_burst(input string tag, input int n, input int last_idx);
    check({tag, "_count"}, obs_data.size(), n);
    for (int i = 0; i < n && i < obs_data.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), obs_data[i], exp_q[i]);
      check($sformatf("%s_last%0d", tag, i), obs_last[i], (i == last_idx));
    end
  endtask

  task automatic ack_to_idle(input string tag);
    enable  = 1'b0;
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check({tag, "_int_clr"}, user_int, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    logic found;
    reset        = 1'b1;
    enable       = 1'b0;
    burst_len    = '0;
    burst_len_tv = 1'b0;
    irq_ack      = 1'b0;
    bus.m_ready  = 1'b0;
    step(3);
    reset = 1'b0;
    step();

    // Reset state
    check("rst_m_valid", bus.m_valid, 1'b0);
    check("rst_m_last", bus.m_last, 1'b0);
    check("rst_m_data", bus.m_data, 64'd0);
    check("rst_rd_en", bus.fifo_rd_en, 1'b0);
    check("rst_user_int", user_int, 1'b0);
    check("rst_words_done", words_done, 32'd0);
    check("rst_tag_err", tag_err, 1'b0);
    check("rst_busy", busy, 1'b0);

    // ---- Basic burst of 4 ----
    new_burst();
    for (int i = 0; i < 4; i++)
      push_word({8'h00, 16'h3333, 16'(16'h4440 + i), 16'h1111, 16'(16'h2220 + i)});
    load_len(32'd4);
    bus.m_ready = 1'b1;
    first_rd    = -1;
    first_vld   = -1;
    enable      = 1'b1;
    wait_xfers(4, 40);
    check_burst("basic", 4, 3);
    check("basic_pattern0", obs_data.size() > 0 ? obs_data[0] : 64'd0,
          64'h11112220_33334440);
    check("basic_consecutive", obs_cyc.size() == 4 ? obs_cyc[3] - obs_cyc[0] : -1, 3);
    check("basic_latency", first_vld - first_rd, 2);
    wait_int("basic_int", 10);
    check("basic_done_cnt", words_done, 32'd4);
    step(3);
    check("basic_int_held", user_int, 1'b1);
    check("basic_no_rd_in_done", bus.fifo_rd_en, 1'b0);
    ack_to_idle("basic");
    check("basic_wd_after_ack", words_done, 32'd4);

    // ---- Backpressure, burst of 8, ready pattern 1,0,0,1 ----
    new_burst();
    for (int i = 0; i < 8; i++) push_word({8'h00, $urandom, $urandom});
    load_len(32'd8);
    stable_viol = 0;
    max_out     = 0;
    enable      = 1'b1;
    k           = 0;
    while (obs_data.size() < 8 && k < 200) begin
      bus.m_ready = (k % 4 == 0) || (k % 4 == 3);
      step();
      k++;
    end
    bus.m_ready = 1'b1;
    check_burst("bp", 8, 7);
    check("bp_stable", stable_viol, 0);
    check("bp_outstanding_le2", max_out <= 2, 1'b1);
    wait_int("bp_int", 10);
    ack_to_idle("bp");

    // ---- Tag error, config guard, FIFO underrun; burst of 12 ----
    new_burst();
    for (int i = 0; i < 12; i++)
      push_word({(i == 2) ? 8'h5A : 8'h00, $urandom, $urandom});
    load_len(32'd12);
    load_len(32'd0);          // zero must be refused
    enable = 1'b1;
    wait_xfers(5, 40);
    burst_len    = 32'd3;     // strobe while running must be ignored
    burst_len_tv = 1'b1;
    step();
    burst_len_tv = 1'b0;
    starve       = 1'b1;
    step(4);
    k = obs_data.size();
    step(6);
    check("ur_no_rd", bus.fifo_rd_en, 1'b0);
    check("ur_no_valid", bus.m_valid, 1'b0);
    check("ur_stalled", obs_data.size(), k);
    check("ur_busy", busy, 1'b1);
    check("tag_err_set", tag_err, 1'b1);
    starve = 1'b0;
    wait_xfers(12, 60);
    check_burst("ur", 12, 11);
    wait_int("ur_int", 10);
    check("tag_err_held_done", tag_err, 1'b1);
    ack_to_idle("ur");
    check("tag_err_held_idle", tag_err, 1'b1);

    // ---- Enable drop after 3 of 16 ----
    new_burst();
    for (int i = 0; i < 16; i++) push_word({8'h00, $urandom, $urandom});
    load_len(32'd16);
    enable = 1'b1;
    step(2);
    check("tag_err_clr_on_start", tag_err, 1'b0);
    wait_xfers(3, 40);
    enable = 1'b0;
    wait_idle("drop_idle", 30);
    check("drop_le5", obs_data.size() <= 5, 1'b1);
    check("drop_ge3", obs_data.size() >= 3, 1'b1);
    check_burst("drop", obs_data.size(), -1);
    check("drop_no_int", user_int, 1'b0);
    check("drop_wd", words_done, obs_data.size());
    flush = 1'b1;
    step();
    flush = 1'b0;

    // ---- Ack in the cycle DONE is entered is ignored ----
    new_burst();
    for (int i = 0; i < 2; i++) push_word({8'h00, $urandom, $urandom});
    load_len(32'd2);
    enable = 1'b1;
    k      = 0;
    found  = 1'b0;
    while (!found && k < 30) begin
      step();
      k++;
      found = bus.m_valid && bus.m_last;
    end
    check("ack_last_seen", found, 1'b1);
    irq_ack = 1'b1;           // coincides with the RUN->DONE edge
    step();
    irq_ack = 1'b0;
    check("ack_early_ignored", user_int, 1'b1);
    step(3);
    check("ack_int_still", user_int, 1'b1);
    check_burst("ack", 2, 1);
    ack_to_idle("ack");

    // ---- Reset mid-burst ----
    new_burst();
    for (int i = 0; i < 8; i++) push_word({8'h00, $urandom, $urandom});
    load_len(32'd8);
    enable = 1'b1;
    wait_xfers(2, 40);
    reset  = 1'b1;
    enable = 1'b0;
    flush  = 1'b1;
    step();
    reset  = 1'b0;
    flush  = 1'b0;
    check("mrst_m_valid", bus.m_valid, 1'b0);
    check("mrst_m_last", bus.m_last, 1'b0);
    check("mrst_m_data", bus.m_data, 64'd0);
    check("mrst_rd_en", bus.fifo_rd_en, 1'b0);
    check("mrst_user_int", user_int, 1'b0);
    check("mrst_words_done", words_done, 32'd0);
    check("mrst_tag_err", tag_err, 1'b0);
    check("mrst_busy", busy, 1'b0);
    step(2);
    check("mrst_buf_empty", bus.m_valid, 1'b0);
    // Default length 1024: ten words must not complete the burst.
    new_burst();
    for (int i = 0; i < 10; i++) push_word({8'h00, $urandom, $urandom});
    enable = 1'b1;
    wait_xfers(10, 60);
    check_burst("dflt", 10, -1);
    step(2);
    check("dflt_no_int", user_int, 1'b0);
    check("dflt_wd", words_done, 32'd10);
    check("dflt_busy", busy, 1'b1);
    enable = 1'b0;
    wait_idle("dflt_idle", 20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
